// File: rtl/led_pkg.sv
// Shared types and default sizing for the LED shift-register driver slice.
package led_pkg;

    localparam int LED_WIDTH   = 8;
    localparam int LED_CLK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } led_state_t;

endpackage

// File: rtl/led_shift595_phase_timer.sv
// Serial phase timer: counts CLK_DIV cycles per phase and flags the last one.
module phase_timer
    import led_pkg::*;
#(
    parameter int CLK_DIV = LED_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_end
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Held at zero while restart is high so the first phase is always full length.
    assign phase_end = !restart && (div == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (restart || phase_end) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

endmodule

// File: rtl/led_shift595.sv
// Serialises vec_leds onto a 74HC595-style chain, retransmitting only on change,
// first use after reset, or an explicit refresh request.
module led_shift595
    import led_pkg::*;
#(
    parameter int WIDTH   = LED_WIDTH,
    parameter int CLK_DIV = LED_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] vec_leds,
    input  logic             refresh,
    output logic             sr_clk,
    output logic             sr_data,
    output logic             sr_latch,
    output logic             sr_oe_n,
    output logic             busy,
    output led_state_t       dbg_state
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    led_state_t       state;
    led_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] frame_q;
    logic [WIDTH-1:0] shown;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bitcnt;
    logic             primed;
    logic             pend;
    logic             start;
    logic             shift_step;
    logic             frame_done;
    logic             phase_end;

    assign dbg_state = state;
    assign shifted   = shreg << 1;

    phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (state == IDLE),
        .phase_end (phase_end)
    );

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        shift_step = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if ((vec_leds != shown) || !primed || refresh || pend) begin
                    state_nxt = SHIFT_LO;
                    start     = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    if (bitcnt == LAST_BIT) begin
                        state_nxt = LATCH;
                    end else begin
                        state_nxt  = SHIFT_LO;
                        shift_step = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pin-level strobes are registered copies of the next state, so every
    // output changes only on a clock edge (or on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr_clk   <= 1'b0;
            sr_data  <= 1'b0;
            sr_latch <= 1'b0;
            sr_oe_n  <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            frame_q  <= '0;
            shown    <= '0;
            bitcnt   <= '0;
            primed   <= 1'b0;
            pend     <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr_clk   <= (state_nxt == SHIFT_HI);
            sr_latch <= (state_nxt == LATCH);
            busy     <= (state_nxt != IDLE);

            if (start) begin
                shreg   <= vec_leds;
                frame_q <= vec_leds;
                sr_data <= vec_leds[WIDTH-1];
                bitcnt  <= '0;
                pend    <= 1'b0;
            end else if (refresh && (state != IDLE)) begin
                pend <= 1'b1;
            end

            if (shift_step) begin
                shreg   <= shifted;
                sr_data <= shifted[WIDTH-1];
                bitcnt  <= bitcnt + BW'(1);
            end

            // Output enable drops only once a complete frame is in the storage register.
            if (frame_done) begin
                shown   <= frame_q;
                primed  <= 1'b1;
                sr_oe_n <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_shift595.sv
// Bench for led_shift595: directed and randomized frames against a '595 pin model.
module tb_led_shift595;
    import led_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_na, rst_nb;
    logic [7:0] vec_a;
    logic [3:0] vec_b;
    logic       refresh_a, refresh_b;

    logic       sr_clk_a, sr_data_a, sr_latch_a, sr_oe_n_a, busy_a;
    logic       sr_clk_b, sr_data_b, sr_latch_b, sr_oe_n_b, busy_b;
    led_state_t dbg_state_a, dbg_state_b;

    led_shift595 #(.WIDTH(8), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_na), .vec_leds(vec_a), .refresh(refresh_a),
        .sr_clk(sr_clk_a), .sr_data(sr_data_a), .sr_latch(sr_latch_a),
        .sr_oe_n(sr_oe_n_a), .busy(busy_a), .dbg_state(dbg_state_a)
    );

    led_shift595 #(.WIDTH(4), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_nb), .vec_leds(vec_b), .refresh(refresh_b),
        .sr_clk(sr_clk_b), .sr_data(sr_data_b), .sr_latch(sr_latch_b),
        .sr_oe_n(sr_oe_n_b), .busy(busy_b), .dbg_state(dbg_state_b)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit sel_b, input int max);
        int n;
        n = 0;
        while ((sel_b ? busy_b : busy_a) && n < max) begin
            tick();
            n++;
        end
        check(sel_b ? "idle_timeout_b" : "idle_timeout_a", 32'(sel_b ? busy_b : busy_a), 32'd0);
    endtask

    // ---------------- '595 pin models ----------------
    logic [7:0] sh_a = '0, st_a = '0;
    logic [3:0] sh_b = '0, st_b = '0;
    always @(posedge sr_clk_a)   sh_a <= {sh_a[6:0], sr_data_a};
    always @(posedge sr_latch_a) st_a <= sh_a;
    always @(posedge sr_clk_b)   sh_b <= {sh_b[2:0], sr_data_b};
    always @(posedge sr_latch_b) st_b <= sh_b;

    // ---------------- scoreboard (instance A) ----------------
    int latch_cnt_a = 0;
    always @(posedge sr_latch_a) begin
        latch_cnt_a++;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("frame_bits", 32'(sh_a), 32'(exp_q.pop_front()));
    end

    // ---------------- timing monitors ----------------
    int busy_run_a = 0, last_len_a = 0, latch_run_a = 0, last_latch_a = 0;
    int rises_a = 0, rises_frame_a = 0, first_rise_a = 0;
    logic prev_clk_a = 1'b0;
    always @(negedge clk) begin
        if (busy_a) busy_run_a++;
        else if (busy_run_a != 0) begin last_len_a = busy_run_a; busy_run_a = 0; end
        if (busy_a && busy_run_a == 1) rises_frame_a = 0;
        if (sr_latch_a) latch_run_a++;
        else if (latch_run_a != 0) begin last_latch_a = latch_run_a; latch_run_a = 0; end
        if (sr_clk_a && !prev_clk_a) begin
            rises_a++;
            if (rises_frame_a == 0) first_rise_a = busy_run_a;
            rises_frame_a++;
        end
        prev_clk_a = sr_clk_a;
    end

    int busy_run_b = 0, last_len_b = 0, latch_run_b = 0, last_latch_b = 0;
    int rises_frame_b = 0, first_rise_b = 0;
    logic prev_clk_b = 1'b0;
    always @(negedge clk) begin
        if (busy_b) busy_run_b++;
        else if (busy_run_b != 0) begin last_len_b = busy_run_b; busy_run_b = 0; end
        if (busy_b && busy_run_b == 1) rises_frame_b = 0;
        if (sr_latch_b) latch_run_b++;
        else if (latch_run_b != 0) begin last_latch_b = latch_run_b; latch_run_b = 0; end
        if (sr_clk_b && !prev_clk_b) begin
            if (rises_frame_b == 0) first_rise_b = busy_run_b;
            rises_frame_b++;
        end
        prev_clk_b = sr_clk_b;
    end

    // ---------------- directed + randomized sequence ----------------
    initial begin
        int         r0, l0, bad, n;
        logic [7:0] v, nv, shown_m;
        logic [3:0] nb;
        bit         r, go;

        rst_na = 1'b0; rst_nb = 1'b0;
        vec_a = 8'hA5; vec_b = 4'h9;
        refresh_a = 1'b0; refresh_b = 1'b0;
        repeat (3) tick();

        check("rst_sr_clk",   32'(sr_clk_a),   32'd0);
        check("rst_sr_data",  32'(sr_data_a),  32'd0);
        check("rst_sr_latch", 32'(sr_latch_a), 32'd0);
        check("rst_sr_oe_n",  32'(sr_oe_n_a),  32'd1);
        check("rst_busy",     32'(busy_a),     32'd0);
        check("rst_state",    32'(dbg_state_a), 32'(IDLE));

        // First frame after reset is unconditional.
        exp_q.push_back(8'hA5);
        rst_na = 1'b1;
        tick();
        check("first_busy", 32'(busy_a), 32'd1);
        check("first_msb",  32'(sr_data_a), 32'd1);
        check("first_oe_high", 32'(sr_oe_n_a), 32'd1);
        wait_idle(1'b0, 200);
        check("frame_len_a",  32'(last_len_a), 32'd68);
        check("latch_len_a",  32'(last_latch_a), 32'd4);
        check("first_rise_a", 32'(first_rise_a), 32'd5);
        check("oe_after_first", 32'(sr_oe_n_a), 32'd0);
        check("shown_a5", 32'(st_a), 32'h0A5);

        // Steady pattern: one frame, then silence.
        vec_a = 8'h3C; exp_q.push_back(8'h3C);
        tick();
        check("3c_start", 32'(busy_a), 32'd1);
        wait_idle(1'b0, 200);
        r0 = rises_a; l0 = latch_cnt_a;
        repeat (1000) tick();
        check("steady_no_clk",   32'(rises_a), 32'(r0));
        check("steady_no_frame", 32'(latch_cnt_a), 32'(l0));
        vec_a = 8'hC3; exp_q.push_back(8'hC3);
        tick();
        check("c3_start", 32'(busy_a), 32'd1);

        // Changes inside a frame are ignored; only the final value follows.
        repeat (9) tick();  vec_a = 8'h01;
        repeat (10) tick(); vec_a = 8'h02;
        repeat (10) tick(); vec_a = 8'h04;
        exp_q.push_back(8'h04);
        wait_idle(1'b0, 200);
        tick();
        check("follow_start", 32'(busy_a), 32'd1);
        wait_idle(1'b0, 200);
        repeat (5) tick();
        check("no_third_frame", 32'(busy_a), 32'd0);
        check("mid_frame_count", 32'(latch_cnt_a), 32'(l0 + 2));

        // Refresh in IDLE, then three pulses while busy -> exactly one extra frame.
        l0 = latch_cnt_a;
        refresh_a = 1'b1; exp_q.push_back(8'h04);
        tick();
        refresh_a = 1'b0;
        check("refresh_start", 32'(busy_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (5) tick();
            refresh_a = 1'b1; tick(); refresh_a = 1'b0;
        end
        exp_q.push_back(8'h04);
        wait_idle(1'b0, 200);
        tick();
        check("pend_start", 32'(busy_a), 32'd1);

        // Refresh on the last LATCH cycle of this frame: one idle cycle, then a new frame.
        repeat (67) tick();
        check("last_latch_cycle", 32'(sr_latch_a), 32'd1);
        refresh_a = 1'b1; exp_q.push_back(8'h04);
        tick();
        refresh_a = 1'b0;
        check("idle_gap", 32'(busy_a), 32'd0);
        tick();
        check("late_refresh_start", 32'(busy_a), 32'd1);
        wait_idle(1'b0, 200);
        repeat (20) tick();
        check("refresh_frame_count", 32'(latch_cnt_a), 32'(l0 + 3));

        // Asynchronous reset halfway through a frame.
        v = 8'($urandom_range(0, 255));
        if (v == 8'h04) v = 8'h5A;
        vec_a = v; exp_q.push_back(v);
        tick();
        check("pre_reset_busy", 32'(busy_a), 32'd1);
        repeat (33) tick();
        #2 rst_na = 1'b0;
        #1;
        check("async_sr_clk",   32'(sr_clk_a),   32'd0);
        check("async_sr_data",  32'(sr_data_a),  32'd0);
        check("async_sr_latch", 32'(sr_latch_a), 32'd0);
        check("async_sr_oe_n",  32'(sr_oe_n_a),  32'd1);
        check("async_busy",     32'(busy_a),     32'd0);
        exp_q.delete();
        tick();
        rst_na = 1'b1; exp_q.push_back(v);
        tick();
        check("post_reset_start", 32'(busy_a), 32'd1);
        bad = 0; n = 0;
        while (busy_a && n < 200) begin
            if (!sr_oe_n_a) bad++;
            tick();
            n++;
        end
        check("post_reset_timeout", 32'(busy_a), 32'd0);
        check("oe_held_high", 32'(bad), 32'd0);
        check("oe_after_relatch", 32'(sr_oe_n_a), 32'd0);
        check("post_reset_len", 32'(last_len_a), 32'd68);

        // Randomized: a frame happens iff the pattern differs from the shown one or refresh is pulsed.
        shown_m = v;
        for (int i = 0; i < 10; i++) begin
            nv = 8'($urandom_range(0, 255));
            r  = ($urandom_range(0, 3) == 0);
            if (!r && $urandom_range(0, 1) == 1) nv = shown_m;
            go = (nv != shown_m) || r;
            vec_a = nv; refresh_a = r;
            tick();
            refresh_a = 1'b0;
            check("rand_start", 32'(busy_a), 32'(go));
            if (go) begin
                exp_q.push_back(nv);
                shown_m = nv;
                wait_idle(1'b0, 200);
                check("rand_len", 32'(last_len_a), 32'd68);
            end
            repeat (2) tick();
        end

        // Narrow, fastest configuration.
        rst_nb = 1'b1;
        tick();
        check("b_start", 32'(busy_b), 32'd1);
        check("b_msb",   32'(sr_data_b), 32'd1);
        wait_idle(1'b1, 50);
        check("b_len",   32'(last_len_b), 32'd9);
        check("b_latch", 32'(last_latch_b), 32'd1);
        check("b_first_rise", 32'(first_rise_b), 32'd2);
        check("b_shown", 32'(st_b), 32'h9);
        check("b_oe",    32'(sr_oe_n_b), 32'd0);
        nb = 4'($urandom_range(0, 15));
        if (nb == 4'h9) nb = 4'h6;
        vec_b = nb;
        tick();
        check("b2_start", 32'(busy_b), 32'd1);
        wait_idle(1'b1, 50);
        check("b2_shown", 32'(st_b), 32'(nb));

        repeat (5) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_shift595.md
# led_shift595

Downstream consumer of the LED test-pattern generator: takes the 8-bit `vec_leds` pattern and serialises it onto an external 74HC595-style shift register (serial clock, data, storage latch, output enable). Retransmits only when the pattern changes or a refresh is requested, so the board LEDs mirror the generator without continuous bus toggling. Sits between the pattern generator and the FPGA pins driving the LED shift register.

## Interface

- `WIDTH`, default 8: pattern width and number of bits shifted per frame.
- `CLK_DIV`, default 4: length of each serial phase in `clk` cycles; must be ≥ 1.
- `clk`, input, 1: sole clock; everything is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `vec_leds`, input, WIDTH: pattern to display; sampled only in IDLE.
- `refresh`, input, 1: forces one retransmit of the current pattern.
- `sr_clk`, output, 1: shift clock to the '595; data is shifted on its rising edge.
- `sr_data`, output, 1: serial data, MSB first.
- `sr_latch`, output, 1: storage-register clock; high for one phase per frame.
- `sr_oe_n`, output, 1: '595 output enable, active-low.
- `busy`, output, 1: high while a frame is in progress.

## Operation

- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- `shown`: a WIDTH-bit register holding the last latched frame. `primed`: a 1-bit flag, cleared by reset and set after the first completed frame. `pend`: a 1-bit flag holding a refresh request.
- **IDLE → SHIFT_LO**
  - Taken when `vec_leds != shown`, or `!primed`, or `refresh`, or `pend`.
  - On that edge: `shreg <= vec_leds`, `sr_data <= vec_leds[WIDTH-1]`, `bitcnt <= 0`, `div <= 0`, `pend <= 0`, `busy <= 1`.
- **SHIFT_LO**
  - `sr_clk = 0` for CLK_DIV cycles, then go to SHIFT_HI.
- **SHIFT_HI**
  - `sr_clk = 1` for CLK_DIV cycles.
  - At the end of the phase, if `bitcnt == WIDTH-1`, go to LATCH.
  - Otherwise: shift `shreg` left, `sr_data <=` next bit, `bitcnt++`, and go to SHIFT_LO.
- **LATCH**
  - `sr_clk = 0`, `sr_latch = 1` for CLK_DIV cycles.
  - On exit: `sr_latch <= 0`, `shown <=` captured frame, `primed <= 1`, `sr_oe_n <= 0`, `busy <= 0`, go to IDLE.
- Phase timing: `div` counts 0..CLK_DIV-1. The phase ends on the cycle where `div == CLK_DIV-1`, and `div` wraps to 0 there. Counter width is `$clog2(CLK_DIV+1)`.
- `refresh` while `busy` sets `pend`. It is not lost, and costs exactly one extra frame regardless of how many pulses arrive.
- `vec_leds` changes while `busy` are ignored. The mismatch against `shown` is re-evaluated in IDLE.
- IDLE always lasts at least one cycle between frames.
- `sr_oe_n` stays high from reset until the first frame has latched. This prevents power-up garbage from showing on the LEDs. It never returns high except on reset.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- Reset values: `sr_clk = 0`, `sr_data = 0`, `sr_latch = 0`, `sr_oe_n = 1`, `busy = 0`. Internal reset values: state IDLE, `shown = 0`, `primed = 0`, `pend = 0`.
- Assertion of `rst_n` mid-frame forces all outputs to their reset values immediately (asynchronously). The partial frame is abandoned. The first frame after release is unconditional (because `primed = 0`).
- Latency: a `vec_leds` change seen in IDLE in cycle N gives `busy = 1` and a valid `sr_data` MSB in cycle N+1. The first `sr_clk` rise is at cycle N+1+CLK_DIV.
- Frame length is (2·WIDTH+1)·CLK_DIV cycles of `busy` (68 at defaults).
- Setup and hold on `sr_data` is CLK_DIV cycles either side of each `sr_clk` rise.
- `sr_latch` rises CLK_DIV cycles after the last `sr_clk` rise, while `sr_clk` is low.
- A refresh in the final cycle of LATCH is still captured by `pend`; the following IDLE cycle starts the new frame.
- CLK_DIV = 1 is legal: each phase is one cycle.

## Structure

- Shared package `led_pkg`: state enum type (IDLE, SHIFT_LO, SHIFT_HI, LATCH) and default constants `LED_WIDTH = 8` and `LED_CLK_DIV = 4`.
- One sub-module, `phase_timer`:
  - Function: the CLK_DIV counter.
  - Inputs: `clk`, `rst_n`, restart.
  - Output: single-cycle `phase_end`.
- The FSM, shift register, `shown`, `pend` and `primed` live in the top module.

## Test plan

- Reset release with `vec_leds = 8'hA5` → one frame with serial bits 1,0,1,0,0,1,0,1. `sr_latch` pulses for 4 cycles; `sr_oe_n` falls on the exit from LATCH; `busy` is high for 68 cycles.
- Steady `vec_leds = 8'h3C` after the first frame → no further `sr_clk` edges over 1000 cycles. Change to 8'hC3 → a new frame starts the next cycle.
- Change `vec_leds` 8'h01 → 8'h02 → 8'h04 at cycles 10, 20 and 30 inside a frame → the in-flight frame completes with its captured value. Exactly one further frame carries 8'h04.
- Three `refresh` pulses while `busy`, with a constant pattern → exactly one extra frame, of the same value.
- Drop `rst_n` low halfway through a frame → outputs go to reset values in the same cycle. After release, a full frame runs and `sr_oe_n` stays high until it latches.
- CLK_DIV = 1, WIDTH = 4, `vec_leds = 4'h9` → a 9-cycle frame with bits 1,0,0,1, and a scoreboard model of the '595 shows 4'h9 after the latch.
